// File: rtl/kij_sequencer.sv
// Instruction sequencer for a 3x3 kernel convolution run: streams weights, activations and psums per tap.
// Optional 2-bit weight mode (double-length kernel load, bank select from kij[0]) via macro KIJ_SEQ_2B_EN.
module kij_sequencer #(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int len_nij = 36,
    parameter int nij_sz  = 6,
    parameter int len_kij = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        mode,
    output logic        sel,
    output logic [3:0]  kij,
    output logic        busy,
    output logic        done
);

`ifdef KIJ_SEQ_2B_EN
    localparam int KLEN = 2 * col;
    localparam bit SEL_EN = 1'b1;
`else
    localparam int KLEN = col;
    localparam bit SEL_EN = 1'b0;
`endif

    // CEN/WEN of both memories high, everything else low.
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_KL0, S_KLOAD, S_GAP, S_AL0, S_EXEC, S_OPRE, S_OWR, S_TAIL
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [3:0]  kij_reg, kij_next;
    logic [15:0] dur;
    logic        last_cyc;
    logic        done_next, acc_next, sel_next;
    logic [33:0] inst_next, inst_reg;
    logic        sel_reg, busy_reg, done_reg, mode_reg;
    logic [31:0] ap_off;

    // State register; outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            kij_reg   <= '0;
            inst_reg  <= IDLE_INST;
            sel_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            kij_reg   <= kij_next;
            inst_reg  <= inst_next;
            sel_reg   <= sel_next;
            busy_reg  <= (state_next != S_IDLE);
            done_reg  <= done_next;
            mode_reg  <= 1'b0;
        end
    end

    always_comb begin
        dur = 16'd1;
        case (state_reg)
            S_KL0:   dur = 16'(KLEN);
            S_KLOAD: dur = 16'(row + KLEN);
            S_GAP:   dur = 16'd10;
            S_AL0:   dur = 16'(len_nij);
            S_EXEC:  dur = 16'(len_nij + KLEN);
            S_OWR:   dur = 16'(len_nij);
            S_TAIL:  dur = 16'd3;
            default: dur = 16'd1;
        endcase
        last_cyc = (cnt_reg == dur - 16'd1);
    end

    // Next-state logic. In OPRE, cnt=0 means waiting for the FIFO, cnt=1 is the prefetch read.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        kij_next   = kij_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = S_KL0;
                    kij_next   = '0;
                end
            end
            S_KL0:   if (last_cyc) begin state_next = S_KLOAD; cnt_next = '0; end
            S_KLOAD: if (last_cyc) begin state_next = S_GAP;   cnt_next = '0; end
            S_GAP:   if (last_cyc) begin state_next = S_AL0;   cnt_next = '0; end
            S_AL0:   if (last_cyc) begin state_next = S_EXEC;  cnt_next = '0; end
            S_EXEC: begin
                if (last_cyc) begin
                    state_next = S_OPRE;
                    cnt_next   = {15'd0, ofifo_valid};
                end
            end
            S_OPRE: begin
                if (cnt_reg == 16'd0) begin
                    cnt_next = {15'd0, ofifo_valid};
                end else begin
                    state_next = S_OWR;
                    cnt_next   = '0;
                end
            end
            S_OWR:   if (last_cyc) begin state_next = S_TAIL;  cnt_next = '0; end
            S_TAIL: begin
                if (last_cyc) begin
                    cnt_next = '0;
                    if (kij_reg == 4'(len_kij - 1)) begin
                        state_next = S_IDLE;
                        kij_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_KL0;
                        kij_next   = kij_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode. The psum base walks back by the tap's (row, col) offset in the input tile.
    always_comb begin
        inst_next = IDLE_INST;
        ap_off    = (32'(kij_next) % 32'd3) + (32'(kij_next) / 32'd3) * 32'(nij_sz);
        acc_next  = (kij_next != 4'd0) &&
                    ((state_next == S_OPRE) || (state_next == S_OWR) ||
                     ((state_next == S_TAIL) && (cnt_next == 16'd0)));
        sel_next  = SEL_EN && (state_next != S_IDLE) && kij_next[0];
        case (state_next)
            S_KL0: begin
                inst_next[19]   = 1'b0;
                inst_next[17:7] = 11'(32'd1024 + 32'(kij_next) * 32'(KLEN) + 32'(cnt_next));
                inst_next[2]    = 1'b1;
            end
            S_KLOAD: begin
                inst_next[3] = 1'b1;
                inst_next[0] = (cnt_next < 16'(KLEN));
            end
            S_AL0: begin
                inst_next[19]   = 1'b0;
                inst_next[17:7] = cnt_next[10:0];
                inst_next[2]    = 1'b1;
            end
            S_EXEC: begin
                inst_next[3] = 1'b1;
                inst_next[1] = (cnt_next < 16'(len_nij));
            end
            S_OPRE: inst_next[6] = (cnt_next == 16'd1);
            S_OWR: begin
                inst_next[6]     = 1'b1;
                inst_next[32]    = 1'b0;
                inst_next[31]    = 1'b0;
                inst_next[30:20] = 11'(32'(cnt_next) - ap_off);
            end
            default: ;
        endcase
        inst_next[33] = acc_next;
    end

    assign inst = inst_reg;
    assign mode = mode_reg;
    assign sel  = sel_reg;
    assign kij  = kij_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_kij_sequencer.sv
// Bench for kij_sequencer: position-based timeline model checked every cycle, plus literal pins.
// Follows the DUT build: define KIJ_SEQ_2B_EN for both to test 2-bit weight mode.
module tb_kij_sequencer;

`ifdef KIJ_SEQ_2B_EN
    localparam int K = 16;
    localparam bit SEL_EN = 1'b1;
    localparam int EXP_TOTAL = 1602;
    localparam int EXP_AX3 = 1072;
    localparam int EXP_KLOAD = 24;
    localparam int EXP_SEL = 712;
`else
    localparam int K = 8;
    localparam bit SEL_EN = 1'b0;
    localparam int EXP_TOTAL = 1386;
    localparam int EXP_AX3 = 1048;
    localparam int EXP_KLOAD = 16;
    localparam int EXP_SEL = 0;
`endif
    localparam int ROW = 8, NIJ = 36, NIJ_SZ = 6, LEN_KIJ = 9;
    localparam logic [33:0] IDLE = 34'h1_800C_0000;

    // Start offsets of each phase inside one tap's timeline.
    localparam int S_KLOAD = K;
    localparam int S_GAP   = S_KLOAD + ROW + K;
    localparam int S_AL0   = S_GAP + 10;
    localparam int S_EXEC  = S_AL0 + NIJ;
    localparam int S_OPRE  = S_EXEC + NIJ + K;
    localparam int S_OWR   = S_OPRE + 1;
    localparam int S_TAIL  = S_OWR + NIJ;
    localparam int SLOT    = S_TAIL + 3;

    logic clk, rst, start, ofifo_valid;
    logic [33:0] inst;
    logic mode, sel, busy, done;
    logic [3:0] kij;

    int checks = 0, failures = 0;

    kij_sequencer dut (
        .clk(clk), .reset(rst), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .mode(mode), .sel(sel), .kij(kij), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: running flag, tap index, position in tap timeline, FIFO-wait flag.
    bit m_run, m_wait, m_done;
    int m_kij, m_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_kij <= 0; m_p <= 0; m_wait <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_run) begin
                if (start) begin
                    m_run <= 1'b1; m_kij <= 0; m_p <= 0; m_wait <= 1'b0;
                end
            end else if (m_p == S_OPRE - 1) begin
                m_p <= S_OPRE;
                m_wait <= !ofifo_valid;
            end else if (m_p == S_OPRE && m_wait) begin
                if (ofifo_valid) m_wait <= 1'b0;
            end else if (m_p == SLOT - 1) begin
                m_p <= 0;
                if (m_kij == LEN_KIJ - 1) begin
                    m_run <= 1'b0; m_kij <= 0; m_done <= 1'b1;
                end else begin
                    m_kij <= m_kij + 1;
                end
            end else begin
                m_p <= m_p + 1;
            end
        end
    end

    function automatic logic [33:0] exp_inst(bit run, int k, int p, bit w);
        logic [33:0] v;
        v = IDLE;
        if (run) begin
            if (p < S_KLOAD) begin
                v[19] = 1'b0; v[2] = 1'b1; v[17:7] = 11'(1024 + k * K + p);
            end else if (p < S_GAP) begin
                v[3] = 1'b1; v[0] = ((p - S_KLOAD) < K);
            end else if (p < S_AL0) begin
                v = IDLE;
            end else if (p < S_EXEC) begin
                v[19] = 1'b0; v[2] = 1'b1; v[17:7] = 11'(p - S_AL0);
            end else if (p < S_OPRE) begin
                v[3] = 1'b1; v[1] = ((p - S_EXEC) < NIJ);
            end else if (p == S_OPRE) begin
                v[6] = !w; v[33] = (k > 0);
            end else if (p < S_TAIL) begin
                v[6] = 1'b1; v[32] = 1'b0; v[31] = 1'b0; v[33] = (k > 0);
                v[30:20] = 11'((2048 - (k % 3 + (k / 3) * NIJ_SZ) + (p - S_OWR)) % 2048);
            end else begin
                v[33] = (k > 0) && (p == S_TAIL);
            end
        end
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Per-run measurements gathered from the DUT outputs.
    int run_id = 0, cyc = 0;
    bit prev_busy = 1'b0;
    int t_start[3], t_done[3], sel_cnt[3], kl0_cnt[3], kload_rd[3], load_cnt[3];
    int acc_cnt[3][16], rd_cnt[3][16];
    int ax_k3[3] = '{-1, -1, -1};
    int ap_k4_first[3] = '{-1, -1, -1};
    int ap_k8_first[3] = '{-1, -1, -1};
    int ap_k8_last[3] = '{-1, -1, -1};
    bit seen_al0[3], done_busy[3];

    // Single compare process: every cycle, all outputs against the model.
    initial begin
        logic [41:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            cyc++;
            exp_v = {exp_inst(m_run, m_kij, m_p, m_wait), 1'b0,
                     SEL_EN && m_run && (m_kij % 2 == 1), 4'(m_kij), m_run, m_done};
            act_v = {inst, mode, sel, kij, busy, done};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t kij=%0d pos=%0d actual={inst=%h mode=%b sel=%b kij=%0d busy=%b done=%b} expected=%h",
                         $time, m_kij, m_p, inst, mode, sel, kij, busy, done, exp_v);
            end
            if (busy && !prev_busy) t_start[run_id] = cyc;
            if (done) begin t_done[run_id] = cyc; done_busy[run_id] = busy; end
            if (busy) begin
                if (inst[33]) acc_cnt[run_id][kij]++;
                if (inst[6]) rd_cnt[run_id][kij]++;
                if (sel) sel_cnt[run_id]++;
                if (kij == 4'd3 && ax_k3[run_id] < 0) ax_k3[run_id] = int'(inst[17:7]);
                if (kij == 4'd0) begin
                    if (inst[2] && !inst[19] && inst[17:7] >= 11'd1024) kl0_cnt[run_id]++;
                    if (inst[2] && !inst[19] && inst[17:7] < 11'd1024) seen_al0[run_id] = 1'b1;
                    if (inst[3] && !seen_al0[run_id]) kload_rd[run_id]++;
                    if (inst[0]) load_cnt[run_id]++;
                end
                if (!inst[32]) begin
                    if (kij == 4'd4 && ap_k4_first[run_id] < 0) ap_k4_first[run_id] = int'(inst[30:20]);
                    if (kij == 4'd8) begin
                        if (ap_k8_first[run_id] < 0) ap_k8_first[run_id] = int'(inst[30:20]);
                        ap_k8_last[run_id] = int'(inst[30:20]);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_inst_idle", int'(inst == IDLE), 1);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // Run 0: FIFO always ready, extra start while busy must be ignored.
        run_id = 0;
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done("run0");
        check("run0_done_busy", int'(done_busy[0]), 0);
        @(negedge clk);
        check("run0_busy_after_done", int'(busy), 0);
        check("run0_done_delay", t_done[0] - t_start[0], EXP_TOTAL);
        check("run0_kl0_ax_kij3", ax_k3[0], EXP_AX3);
        check("run0_owr_ap_kij4_first", ap_k4_first[0], 2041);
        check("run0_owr_ap_kij8_first", ap_k8_first[0], 2034);
        check("run0_owr_ap_kij8_last", ap_k8_last[0], 21);
        check("run0_acc_kij0", acc_cnt[0][0], 0);
        check("run0_acc_kij1", acc_cnt[0][1], 38);
        check("run0_kl0_len", kl0_cnt[0], K);
        check("run0_kload_len", kload_rd[0], EXP_KLOAD);
        check("run0_load_len", load_cnt[0], K);
        check("run0_sel_cycles", sel_cnt[0], EXP_SEL);
        check("run0_rd_kij2", rd_cnt[0][2], 37);

        // Run 1: FIFO not ready for 20 cycles at first OPRE, then reset mid-EXEC of kij 5.
        run_id = 1;
        ofifo_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (S_OPRE + 19) @(negedge clk);
        ofifo_valid = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 4000 && !hit; i++) begin
                @(negedge clk);
                if (m_kij == 5 && m_p == S_EXEC + 10) hit = 1'b1;
            end
            check("run1_reach_kij5_exec", int'(hit), 1);
        end
        check("run1_rd_kij0", rd_cnt[1][0], 37);
        check("run1_acc_kij0", acc_cnt[1][0], 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrun_reset_inst", int'(inst == IDLE), 1);
        check("midrun_reset_kij", int'(kij), 0);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_sel", int'(sel), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset_stays_idle", int'(busy), 0);

        // Run 2: fresh start after reset runs all taps from kij 0.
        run_id = 2;
        pulse_start();
        check("run2_starts_kij0", int'(kij), 0);
        wait_done("run2");
        check("run2_done_delay", t_done[2] - t_start[2], EXP_TOTAL);
        check("run2_kl0_ax_kij3", ax_k3[2], EXP_AX3);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
